// File: rtl/ir_nec_frame_rx_if.sv
// rtl/ir_nec_frame_rx_if.sv - decoded-frame output bundle of the NEC IR frame receiver
interface ir_nec_frame_rx_if #(
   parameter int SIGNAL_WIDTH = 32
);
   logic [SIGNAL_WIDTH-1:0] o_code;
   logic                    o_valid;
   logic                    o_busy;
   logic                    o_error;
   logic                    o_repeat;

   modport master (output o_code, o_valid, o_busy, o_error, o_repeat);
   modport slave  (input  o_code, o_valid, o_busy, o_error, o_repeat);
endinterface

// File: rtl/ir_nec_frame_rx.sv
// rtl/ir_nec_frame_rx.sv - NEC IR frame receiver: input sync, mark/space timing, frame FSM
// Define IR_REPEAT_EN to decode NEC repeat frames onto o_repeat.
module ir_nec_frame_rx #(
   parameter int CLKS_PER_US  = 50,
   parameter int SIGNAL_WIDTH = 32,
   parameter int TIMEOUT_US   = 12000
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_ir_signal,
   ir_nec_frame_rx_if.master rx
);
   localparam int PRE_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
   localparam int CNT_W = $clog2(SIGNAL_WIDTH + 1);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLKS_PER_US - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIGNAL_WIDTH - 1);
   localparam logic [15:0]      TIMEOUT  = 16'(TIMEOUT_US);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEAD_MARK,
      ST_LEAD_SPACE,
      ST_BIT_MARK,
      ST_BIT_SPACE,
      ST_STOP_DAT
`ifdef IR_REPEAT_EN
      , ST_STOP_REP
`endif
   } state_t;

   state_t                  state_q, state_d;
   logic                    sync1_q, sync1_d, sync2_q, sync2_d, lvl_q, lvl_d;
   logic [PRE_W-1:0]        pre_q, pre_d;
   logic [15:0]             us_q, us_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [SIGNAL_WIDTH-1:0] shift_q, shift_d, code_q, code_d;
   logic                    valid_q, valid_d, error_q, error_d;
`ifdef IR_REPEAT_EN
   logic                    repeat_q, repeat_d;
`endif
   logic                    rise, fall, fail;
   logic                    mark_ok, space_zero, space_one;

   function automatic logic in_win(input logic [15:0] w, input int lo, input int hi);
      return (w >= 16'(lo)) && (w <= 16'(hi));
   endfunction

   assign rise       = sync2_q & ~lvl_q;
   assign fall       = ~sync2_q & lvl_q;
   assign mark_ok    = in_win(us_q, 300, 800);
   assign space_zero = in_win(us_q, 300, 800);
   assign space_one  = in_win(us_q, 1300, 2000);

   always_comb begin
      sync1_d  = i_ir_signal;
      sync2_d  = sync1_q;
      lvl_d    = sync2_q;
      pre_d    = pre_q;
      us_d     = us_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      code_d   = code_q;
      valid_d  = 1'b0;
      error_d  = 1'b0;
`ifdef IR_REPEAT_EN
      repeat_d = 1'b0;
`endif
      state_d  = state_q;
      fail     = 1'b0;

      // The edge cycle itself is the first clock of the new interval, so width == elapsed us exactly.
      if (rise || fall) begin
         if (CLKS_PER_US == 1) begin
            pre_d = '0;
            us_d  = 16'd1;
         end else begin
            pre_d = PRE_W'(1);
            us_d  = '0;
         end
      end else if (pre_q == PRE_LAST) begin
         pre_d = '0;
         if (us_q != 16'hFFFF) us_d = us_q + 16'd1;
      end else begin
         pre_d = pre_q + 1'b1;
      end

      case (state_q)
         ST_IDLE: if (fall) state_d = ST_LEAD_MARK;
         ST_LEAD_MARK: if (rise) begin
            if (in_win(us_q, 8000, 10000)) state_d = ST_LEAD_SPACE;
            else fail = 1'b1;
         end
         ST_LEAD_SPACE: if (fall) begin
            if (in_win(us_q, 4000, 5000)) begin
               state_d = ST_BIT_MARK;
               cnt_d   = '0;
            end
`ifdef IR_REPEAT_EN
            else if (in_win(us_q, 1750, 2750)) state_d = ST_STOP_REP;
`endif
            else fail = 1'b1;
         end
         ST_BIT_MARK: if (rise) begin
            if (mark_ok) state_d = ST_BIT_SPACE;
            else fail = 1'b1;
         end
         ST_BIT_SPACE: if (fall) begin
            if (space_zero || space_one) begin
               shift_d = {space_one, shift_q[SIGNAL_WIDTH-1:1]};
               cnt_d   = cnt_q + 1'b1;
               state_d = (cnt_q == CNT_LAST) ? ST_STOP_DAT : ST_BIT_MARK;
            end else begin
               fail = 1'b1;
            end
         end
         ST_STOP_DAT: if (rise) begin
            if (mark_ok) begin
               code_d  = shift_q;
               valid_d = 1'b1;
               state_d = ST_IDLE;
            end else begin
               fail = 1'b1;
            end
         end
`ifdef IR_REPEAT_EN
         ST_STOP_REP: if (rise) begin
            if (mark_ok) begin
               repeat_d = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               fail = 1'b1;
            end
         end
`endif
         default: state_d = ST_IDLE;
      endcase

      // Timeout overrides anything an edge in the same cycle would have done.
      if (state_q != ST_IDLE && us_q >= TIMEOUT) fail = 1'b1;

      if (fail) begin
         state_d  = ST_IDLE;
         error_d  = 1'b1;
         valid_d  = 1'b0;
         code_d   = code_q;
`ifdef IR_REPEAT_EN
         repeat_d = 1'b0;
`endif
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q  <= ST_IDLE;
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         lvl_q    <= 1'b1;
         pre_q    <= '0;
         us_q     <= '0;
         cnt_q    <= '0;
         shift_q  <= '0;
         code_q   <= '0;
         valid_q  <= 1'b0;
         error_q  <= 1'b0;
`ifdef IR_REPEAT_EN
         repeat_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         lvl_q    <= lvl_d;
         pre_q    <= pre_d;
         us_q     <= us_d;
         cnt_q    <= cnt_d;
         shift_q  <= shift_d;
         code_q   <= code_d;
         valid_q  <= valid_d;
         error_q  <= error_d;
`ifdef IR_REPEAT_EN
         repeat_q <= repeat_d;
`endif
      end
   end

   assign rx.o_code  = code_q;
   assign rx.o_valid = valid_q;
   assign rx.o_busy  = (state_q != ST_IDLE);
   assign rx.o_error = error_q;
`ifdef IR_REPEAT_EN
   assign rx.o_repeat = repeat_q;
`else
   assign rx.o_repeat = 1'b0;
`endif
endmodule

// File: tb/tb_ir_nec_frame_rx.sv
// tb/tb_ir_nec_frame_rx.sv - directed bench for the NEC IR frame receiver, independent lanes run side by side
`timescale 1ns/1ps
module tb_ir_nec_frame_rx;
   localparam int NL = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        ir      [NL];
   logic        rst     [NL];
   logic [31:0] code_m  [NL];
   logic        valid_m [NL];
   logic        busy_m  [NL];
   logic        err_m   [NL];
   logic        rep_m   [NL];
   int          n_valid [NL];
   int          n_err   [NL];
   int          n_rep   [NL];
   int          n_clash [NL];
   bit          strobe_prev [NL];
   int          vectors = 0;
   int          miscompares = 0;

   // Last lane is 24 bits wide so the reset-mid-frame scenario fits the cycle budget.
   for (genvar k = 0; k < NL; k++) begin : g_lane
      localparam int W = (k == NL - 1) ? 24 : 32;
      ir_nec_frame_rx_if #(.SIGNAL_WIDTH(W)) rx_if ();
      ir_nec_frame_rx #(.CLKS_PER_US(1), .SIGNAL_WIDTH(W), .TIMEOUT_US(12000)) dut (
         .i_clk       (clk),
         .i_reset     (rst[k]),
         .i_ir_signal (ir[k]),
         .rx          (rx_if)
      );
      assign code_m[k]  = 32'(rx_if.o_code);
      assign valid_m[k] = rx_if.o_valid;
      assign busy_m[k]  = rx_if.o_busy;
      assign err_m[k]   = rx_if.o_error;
      assign rep_m[k]   = rx_if.o_repeat;
   end

   always @(negedge clk) begin : mon
      int s;
      for (int k = 0; k < NL; k++) begin
         s = int'(valid_m[k] === 1'b1) + int'(err_m[k] === 1'b1) + int'(rep_m[k] === 1'b1);
         if (valid_m[k] === 1'b1) n_valid[k]++;
         if (err_m[k] === 1'b1)   n_err[k]++;
         if (rep_m[k] === 1'b1)   n_rep[k]++;
         if (s > 1 || (s != 0 && strobe_prev[k])) n_clash[k]++;
         strobe_prev[k] = (s != 0);
      end
   end

   task automatic level(input int l, input logic v, input int n);
      ir[l] = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bits(input int l, input logic [31:0] c, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         level(l, 1'b0, 560);
         level(l, 1'b1, c[i] ? 1690 : 560);
      end
   endtask

   task automatic test_reset();
      for (int k = 0; k < NL; k++) begin
         rst[k] = 1'b1;
         ir[k]  = 1'b1;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < NL; k++) begin
         vectors++; if (code_m[k] !== 32'h0) begin miscompares++; $display("FAIL reset_code lane %0d: got %h want 0", k, code_m[k]); end
         vectors++; if (valid_m[k] !== 1'b0) begin miscompares++; $display("FAIL reset_valid lane %0d: got %b want 0", k, valid_m[k]); end
         vectors++; if (busy_m[k] !== 1'b0) begin miscompares++; $display("FAIL reset_busy lane %0d: got %b want 0", k, busy_m[k]); end
         vectors++; if (err_m[k] !== 1'b0) begin miscompares++; $display("FAIL reset_error lane %0d: got %b want 0", k, err_m[k]); end
         vectors++; if (rep_m[k] !== 1'b0) begin miscompares++; $display("FAIL reset_repeat lane %0d: got %b want 0", k, rep_m[k]); end
         rst[k] = 1'b0;
      end
      repeat (5) @(negedge clk);
   endtask

   task automatic test_frame(input int l);
      int v0, e0;
      v0 = n_valid[l];
      e0 = n_err[l];
      level(l, 1'b0, 9000);
      vectors++; if (busy_m[l] !== 1'b1) begin miscompares++; $display("FAIL frame_busy_in_leader: got %b want 1", busy_m[l]); end
      level(l, 1'b1, 4500);
      send_bits(l, 32'h00FF_30CF, 32);
      level(l, 1'b0, 560);
      level(l, 1'b1, 20);
      vectors++; if (n_valid[l] - v0 != 1) begin miscompares++; $display("FAIL frame_valid_count: got %0d want 1", n_valid[l] - v0); end
      vectors++; if (code_m[l] !== 32'h00FF_30CF) begin miscompares++; $display("FAIL frame_code: got %h want 00ff30cf", code_m[l]); end
      vectors++; if (busy_m[l] !== 1'b0) begin miscompares++; $display("FAIL frame_busy_after: got %b want 0", busy_m[l]); end
      vectors++; if (n_err[l] != e0) begin miscompares++; $display("FAIL frame_no_error: got %0d want %0d", n_err[l], e0); end
      vectors++; if (n_clash[l] != 0) begin miscompares++; $display("FAIL frame_strobe_clash: got %0d want 0", n_clash[l]); end
   endtask

   task automatic test_timeout(input int l);
      int e0, v0;
      level(l, 1'b0, 9000);
      level(l, 1'b1, 4500);
      send_bits(l, 32'h0, 16);
      level(l, 1'b0, 560);
      e0 = n_err[l];
      v0 = n_valid[l];
      level(l, 1'b1, 11990);
      vectors++; if (n_err[l] != e0) begin miscompares++; $display("FAIL timeout_early: got %0d errors want %0d", n_err[l], e0); end
      vectors++; if (busy_m[l] !== 1'b1) begin miscompares++; $display("FAIL timeout_busy_before: got %b want 1", busy_m[l]); end
      repeat (20) @(negedge clk);
      vectors++; if (n_err[l] != e0 + 1) begin miscompares++; $display("FAIL timeout_error: got %0d want %0d", n_err[l], e0 + 1); end
      vectors++; if (busy_m[l] !== 1'b0) begin miscompares++; $display("FAIL timeout_idle: got %b want 0", busy_m[l]); end
      vectors++; if (n_valid[l] != v0) begin miscompares++; $display("FAIL timeout_no_valid: got %0d want %0d", n_valid[l], v0); end
   endtask

   task automatic test_boundary_ok(input int l);
      int v0, e0;
      v0 = n_valid[l];
      e0 = n_err[l];
      level(l, 1'b0, 9000);
      level(l, 1'b1, 4500);
      level(l, 1'b0, 560);
      level(l, 1'b1, 800);
      level(l, 1'b0, 560);
      level(l, 1'b1, 1300);
      send_bits(l, 32'h0, 30);
      level(l, 1'b0, 560);
      level(l, 1'b1, 20);
      vectors++; if (n_valid[l] - v0 != 1) begin miscompares++; $display("FAIL bound_ok_valid: got %0d want 1", n_valid[l] - v0); end
      vectors++; if (code_m[l] !== 32'h0000_0002) begin miscompares++; $display("FAIL bound_800_1300_code: got %h want 00000002", code_m[l]); end
      vectors++; if (n_err[l] != e0) begin miscompares++; $display("FAIL bound_ok_no_error: got %0d want %0d", n_err[l], e0); end
   endtask

   task automatic test_repeat(input int l);
      logic [31:0] c0;
      int e0, r0, v0;
      c0 = code_m[l];
      e0 = n_err[l];
      r0 = n_rep[l];
      v0 = n_valid[l];
      level(l, 1'b0, 9000);
      level(l, 1'b1, 2250);
      level(l, 1'b0, 560);
      level(l, 1'b1, 20);
`ifdef IR_REPEAT_EN
      vectors++; if (n_rep[l] != r0 + 1) begin miscompares++; $display("FAIL repeat_pulse: got %0d want %0d", n_rep[l], r0 + 1); end
      vectors++; if (n_err[l] != e0) begin miscompares++; $display("FAIL repeat_no_error: got %0d want %0d", n_err[l], e0); end
`else
      vectors++; if (n_err[l] != e0 + 1) begin miscompares++; $display("FAIL repeat_error: got %0d want %0d", n_err[l], e0 + 1); end
      vectors++; if (n_rep[l] != r0) begin miscompares++; $display("FAIL repeat_tied_low: got %0d want %0d", n_rep[l], r0); end
`endif
      vectors++; if (code_m[l] !== c0) begin miscompares++; $display("FAIL repeat_code_held: got %h want %h", code_m[l], c0); end
      vectors++; if (n_valid[l] != v0) begin miscompares++; $display("FAIL repeat_no_valid: got %0d want %0d", n_valid[l], v0); end
      vectors++; if (n_clash[l] != 0) begin miscompares++; $display("FAIL repeat_strobe_clash: got %0d want 0", n_clash[l]); end
   endtask

   task automatic test_boundary_err(input int l);
      int e0, v0, w;
      for (int i = 0; i < 2; i++) begin
         w  = (i == 0) ? 801 : 2001;
         e0 = n_err[l];
         v0 = n_valid[l];
         level(l, 1'b0, 9000);
         level(l, 1'b1, 4500);
         level(l, 1'b0, 560);
         level(l, 1'b1, w);
         level(l, 1'b0, 10);
         vectors++; if (n_err[l] != e0 + 1) begin miscompares++; $display("FAIL bound_space_%0d_error: got %0d want %0d", w, n_err[l], e0 + 1); end
         vectors++; if (busy_m[l] !== 1'b0) begin miscompares++; $display("FAIL bound_space_%0d_idle: got %b want 0", w, busy_m[l]); end
         level(l, 1'b0, 550);
         level(l, 1'b1, 100);
         vectors++; if (n_valid[l] != v0) begin miscompares++; $display("FAIL bound_space_%0d_no_valid: got %0d want %0d", w, n_valid[l], v0); end
      end
   endtask

   task automatic test_bad_leader(input int l);
      logic [31:0] c0;
      int e0, v0;
      c0 = code_m[l];
      e0 = n_err[l];
      v0 = n_valid[l];
      level(l, 1'b0, 7000);
      level(l, 1'b1, 10);
      vectors++; if (n_err[l] != e0 + 1) begin miscompares++; $display("FAIL short_leader_error: got %0d want %0d", n_err[l], e0 + 1); end
      level(l, 1'b1, 4490);
      send_bits(l, 32'h00FF_30CF, 8);
      level(l, 1'b0, 560);
      level(l, 1'b1, 20);
      vectors++; if (n_valid[l] != v0) begin miscompares++; $display("FAIL short_leader_no_valid: got %0d want %0d", n_valid[l], v0); end
      vectors++; if (code_m[l] !== c0) begin miscompares++; $display("FAIL short_leader_code_held: got %h want %h", code_m[l], c0); end
   endtask

   task automatic test_reset_mid(input int l);
      int v0;
      level(l, 1'b0, 9000);
      level(l, 1'b1, 4500);
      send_bits(l, 32'h0, 20);
      level(l, 1'b0, 100);
      vectors++; if (busy_m[l] !== 1'b1) begin miscompares++; $display("FAIL midreset_busy_before: got %b want 1", busy_m[l]); end
      rst[l] = 1'b1;
      @(negedge clk);
      vectors++; if (busy_m[l] !== 1'b0) begin miscompares++; $display("FAIL midreset_busy: got %b want 0", busy_m[l]); end
      vectors++; if (code_m[l] !== 32'h0) begin miscompares++; $display("FAIL midreset_code: got %h want 0", code_m[l]); end
      vectors++; if (valid_m[l] !== 1'b0 || err_m[l] !== 1'b0 || rep_m[l] !== 1'b0) begin miscompares++; $display("FAIL midreset_strobes: got %b%b%b want 000", valid_m[l], err_m[l], rep_m[l]); end
      rst[l] = 1'b0;
      level(l, 1'b0, 460);
      level(l, 1'b1, 300);
      v0 = n_valid[l];
      level(l, 1'b0, 9000);
      level(l, 1'b1, 4500);
      send_bits(l, 32'h0080_0001, 24);
      level(l, 1'b0, 560);
      level(l, 1'b1, 20);
      vectors++; if (n_valid[l] != v0 + 1) begin miscompares++; $display("FAIL midreset_next_valid: got %0d want %0d", n_valid[l], v0 + 1); end
      vectors++; if (code_m[l] !== 32'h0080_0001) begin miscompares++; $display("FAIL midreset_next_code: got %h want 00800001", code_m[l]); end
   endtask

   initial begin
      test_reset();
      fork
         test_frame(0);
         test_timeout(1);
         begin
            test_boundary_ok(2);
            test_repeat(2);
         end
         begin
            test_boundary_err(3);
            test_bad_leader(3);
         end
         test_reset_mid(4);
      join
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
